// File: rtl/evm_tally.sv
// evm_tally: vote capture and tally core with one-vote-per-ballot arming,
// post-vote lockout, multi-press rejection, saturating counters and a
// poll-close gate on per-candidate results, leader and tie.
module evm_tally #(
    parameter  int unsigned NUM_CAND = 4,
    parameter  int unsigned CNT_W    = 8,
    parameter  int unsigned LOCK_CYC = 4,
    localparam int unsigned SEL_W    = $clog2(NUM_CAND)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ballot_en_i,
    input  logic [NUM_CAND-1:0]    vote_i,
    input  logic                   close_i,
    input  logic [SEL_W-1:0]       rd_sel_i,
    output logic                   armed_o,
    output logic                   vote_ack_o,
    output logic                   vote_err_o,
    output logic                   closed_o,
    output logic                   sat_o,
    output logic [CNT_W+SEL_W-1:0] total_o,
    output logic [CNT_W-1:0]       rd_count_o,
    output logic [SEL_W-1:0]       leader_o,
    output logic                   tie_o
);

    localparam int unsigned TOT_W  = CNT_W + SEL_W;
    localparam int unsigned LOCK_W = $clog2(LOCK_CYC) + 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ARMED  = 2'd1;
    localparam logic [1:0] S_LOCK   = 2'd2;
    localparam logic [1:0] S_CLOSED = 2'd3;

    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_CYC - 1);

    logic [1:0]          state_q, state_d;
    logic [LOCK_W-1:0]   lock_cnt_q, lock_cnt_d;
    logic [NUM_CAND-1:0] vote_q;
    logic                close_q;
    logic [CNT_W-1:0]    count_q [NUM_CAND];
    logic [CNT_W-1:0]    count_d [NUM_CAND];
    logic [TOT_W-1:0]    total_q, total_d;
    logic                ack_q, ack_d;
    logic                err_q, err_d;
    logic                sat_q, sat_d;
    logic                armed_q, closed_q;
    logic [CNT_W-1:0]    rd_count_q;
    logic [SEL_W-1:0]    leader_q;
    logic                tie_q;

    logic [SEL_W-1:0]    vidx_c;
    logic                one_hot_c;
    logic [SEL_W-1:0]    lead_c;
    logic [CNT_W-1:0]    max_c;
    logic [SEL_W:0]      n_eq_c;
    logic                tie_c;

    // Input stage: buttons and close are resolved together one edge after capture
    always_ff @(posedge clk) begin
        if (rst) begin
            vote_q  <= '0;
            close_q <= 1'b0;
        end else begin
            vote_q  <= vote_i;
            close_q <= close_i;
        end
    end

    // Decode the pressed button: single-press flag and its index
    always_comb begin
        vidx_c    = '0;
        one_hot_c = (vote_q != '0) && ((vote_q & (vote_q - NUM_CAND'(1))) == '0);
        for (int unsigned i = 0; i < NUM_CAND; i++) begin
            if (vote_q[i]) vidx_c = SEL_W'(i);
        end
    end

    // Leader (lowest index wins ties) and tie detection over the counter bank
    always_comb begin
        lead_c = '0;
        max_c  = count_q[0];
        n_eq_c = '0;
        for (int unsigned i = 1; i < NUM_CAND; i++) begin
            if (count_q[i] > max_c) begin
                max_c  = count_q[i];
                lead_c = SEL_W'(i);
            end
        end
        for (int unsigned i = 0; i < NUM_CAND; i++) begin
            if (count_q[i] == max_c) n_eq_c = n_eq_c + (SEL_W+1)'(1);
        end
        tie_c = (n_eq_c > (SEL_W+1)'(1));
    end

    // Next-state, tally and pulse logic
    always_comb begin
        state_d    = state_q;
        lock_cnt_d = '0;
        count_d    = count_q;
        total_d    = total_q;
        ack_d      = 1'b0;
        err_d      = 1'b0;
        sat_d      = sat_q;
        case (state_q)
            S_IDLE: begin
                if (close_q)          state_d = S_CLOSED;
                else if (ballot_en_i) state_d = S_ARMED;
            end
            S_ARMED: begin
                if (one_hot_c) begin
                    ack_d = 1'b1;
                    if (count_q[vidx_c] != CNT_MAX) begin
                        count_d[vidx_c] = count_q[vidx_c] + CNT_W'(1);
                        total_d         = total_q + TOT_W'(1);
                    end
                    state_d = close_q ? S_CLOSED : S_LOCK;
                end else begin
                    if (vote_q != '0) err_d = 1'b1;
                    if (close_q) state_d = S_CLOSED;
                end
            end
            S_LOCK: begin
                lock_cnt_d = (lock_cnt_q == LOCK_LAST) ? lock_cnt_q
                                                       : lock_cnt_q + LOCK_W'(1);
                if (close_q)
                    state_d = S_CLOSED;
                else if ((lock_cnt_q == LOCK_LAST) && (vote_q == '0))
                    state_d = S_IDLE;
            end
            S_CLOSED: begin
                state_d = S_CLOSED;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        for (int unsigned i = 0; i < NUM_CAND; i++) begin
            if (count_d[i] == CNT_MAX) sat_d = 1'b1;
        end
    end

    // State, tally and status registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            lock_cnt_q <= '0;
            count_q    <= '{default: '0};
            total_q    <= '0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            sat_q      <= 1'b0;
            armed_q    <= 1'b0;
            closed_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            lock_cnt_q <= lock_cnt_d;
            count_q    <= count_d;
            total_q    <= total_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            sat_q      <= sat_d;
            armed_q    <= (state_d == S_ARMED);
            closed_q   <= (state_d == S_CLOSED);
        end
    end

    // Result readout, hidden until the poll is closed
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_count_q <= '0;
            leader_q   <= '0;
            tie_q      <= 1'b0;
        end else begin
            if ((state_q == S_CLOSED) && ({1'b0, rd_sel_i} < (SEL_W+1)'(NUM_CAND)))
                rd_count_q <= count_q[rd_sel_i];
            else
                rd_count_q <= '0;
            leader_q <= (state_q == S_CLOSED) ? lead_c : '0;
            tie_q    <= (state_q == S_CLOSED) && tie_c;
        end
    end

    assign armed_o    = armed_q;
    assign vote_ack_o = ack_q;
    assign vote_err_o = err_q;
    assign closed_o   = closed_q;
    assign sat_o      = sat_q;
    assign total_o    = total_q;
    assign rd_count_o = rd_count_q;
    assign leader_o   = leader_q;
    assign tie_o      = tie_q;

endmodule
